// File: rtl/fetch_stage.sv
// Thumb instruction fetch stage: owns the fetch PC, issues credit-limited in-order
// memory requests, buffers responses in a small skid FIFO and feeds decode one slot per cycle.
module fetch_stage #(
  parameter int unsigned      WORD        = 32,
  parameter int unsigned      INSTR_WIDTH = 16,
  parameter logic [WORD-1:0]  RESET_PC    = '0,
  parameter logic [WORD-1:0]  PC_INC      = WORD'(2),
  parameter int unsigned      DEPTH       = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [WORD-1:0]        branch_target_i,
  output logic                   imem_req_o,
  output logic [WORD-1:0]        imem_addr_o,
  input  logic                   imem_ready_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic                   is_valid_o,
  output logic [WORD-1:0]        program_counter_o
);

  // Handshakes: a request transfers on a cycle with imem_req_o & imem_ready_i;
  // a response transfers on any cycle with imem_rvalid_i (no back-pressure, in order);
  // decode consumes the output slot on every cycle with stall_i low.

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 2;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD-1:0]        r_fetch_pc;
  logic [WORD-1:0]        r_resp_pc;
  logic [CNT_W-1:0]       r_inflight;
  logic [CNT_W-1:0]       r_drop_cnt;
  logic [CNT_W-1:0]       r_fifo_count;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [INSTR_WIDTH-1:0] r_fifo_instr [DEPTH];
  logic [WORD-1:0]        r_fifo_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [WORD-1:0]        r_out_pc;
  logic                   r_out_valid;

  logic [SUM_W-1:0]       w_credit_used;
  logic                   w_has_credit;
  logic                   w_issue;
  logic                   w_resp_good;
  logic                   w_resp_stale;
  logic                   w_resp_take;
  logic                   w_out_load;
  logic                   w_fifo_empty;
  logic                   w_bypass;
  logic                   w_push;
  logic                   w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stale responses still owed by memory count against credit, so the FIFO can
  // always absorb every response that will eventually be kept.
  assign w_credit_used = SUM_W'(r_inflight) + SUM_W'(r_drop_cnt) + SUM_W'(r_fifo_count);
  assign w_has_credit  = w_credit_used < SUM_W'(DEPTH);

  assign imem_req_o   = !reset_i && !flush_i && w_has_credit;
  assign imem_addr_o  = r_fetch_pc;
  assign w_issue      = imem_req_o && imem_ready_i;

  assign w_resp_good  = imem_rvalid_i && (r_drop_cnt == '0);
  assign w_resp_stale = imem_rvalid_i && (r_drop_cnt != '0);
  assign w_resp_take  = w_resp_good && !flush_i;

  assign w_out_load   = !stall_i && !flush_i;
  assign w_fifo_empty = (r_fifo_count == '0);
  assign w_bypass     = w_resp_take && w_fifo_empty && w_out_load;
  assign w_push       = w_resp_take && !w_bypass;
  assign w_pop        = w_out_load && !w_fifo_empty;

  assign instruction_o     = r_instr;
  assign is_valid_o        = r_out_valid;
  assign program_counter_o = r_out_pc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else if (flush_i) begin
      r_fetch_pc <= branch_target_i;
      r_resp_pc  <= branch_target_i;
      r_inflight <= '0;
      // Everything still owed by memory becomes stale; one arriving now is discarded here.
      r_drop_cnt <= r_drop_cnt + r_inflight - CNT_W'(imem_rvalid_i);
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + PC_INC;
      end
      if (w_resp_take) begin
        r_resp_pc <= r_resp_pc + PC_INC;
      end
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_resp_good);
      if (w_resp_stale) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_fifo_count <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      r_fifo_count <= r_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  // The FIFO head always takes precedence over a fresh response to keep order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_instr     <= '0;
      r_out_pc    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_out_load) begin
      if (w_pop) begin
        r_instr     <= r_fifo_instr[r_rd_ptr];
        r_out_pc    <= r_fifo_pc[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else if (w_bypass) begin
        r_instr     <= imem_rdata_i;
        r_out_pc    <= r_resp_pc;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  a_no_orphan_response: assert property (@(posedge clk_i) disable iff (reset_i)
    imem_rvalid_i |-> (r_inflight != '0 || r_drop_cnt != '0));

  a_fifo_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    r_fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-configurable in-order memory model plus
// per-scenario tasks checking request, address and output-slot behaviour cycle by cycle.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [15:0] imem_rdata_i = '0;
  logic [15:0] instruction_o;
  logic        is_valid_o;
  logic [31:0] program_counter_o;

  int tests_run = 0;
  int tests_failed = 0;
  int mem_lat = 1;
  int cyc = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  always #5 clk_i = ~clk_i;

  fetch_stage dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .branch_target_i   (branch_target_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ready_i      (imem_ready_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .instruction_o     (instruction_o),
    .is_valid_o        (is_valid_o),
    .program_counter_o (program_counter_o)
  );

  function automatic logic [15:0] mem_data(input logic [31:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  // Memory model: a request accepted in cycle N is answered in cycle N+mem_lat.
  always @(posedge clk_i) begin
    if (reset_i) begin
      q_addr.delete();
      q_due.delete();
      imem_rvalid_i <= 1'b0;
    end else begin
      if (imem_req_o && imem_ready_i) begin
        q_addr.push_back(imem_addr_o);
        q_due.push_back(cyc + mem_lat);
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc + 1) begin
        imem_rvalid_i <= 1'b1;
        imem_rdata_i  <= mem_data(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rvalid_i <= 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  task automatic do_reset(input int lat);
    mem_lat = lat;
    imem_ready_i = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    branch_target_i = '0;
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    tests_run++;
    if (imem_req_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req_o);
    end
    tests_run++;
    if (imem_addr_o !== 32'h0) begin
      tests_failed++; $display("FAIL reset_addr: got %h want 00000000", imem_addr_o);
    end
    tests_run++;
    if (is_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b want 0", is_valid_o);
    end
    tests_run++;
    if (instruction_o !== 16'h0) begin
      tests_failed++; $display("FAIL reset_instr: got %h want 0000", instruction_o);
    end
    tests_run++;
    if (program_counter_o !== 32'h0) begin
      tests_failed++; $display("FAIL reset_pc: got %h want 00000000", program_counter_o);
    end
  endtask

  task automatic test_stream();
    do_reset(1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      tests_run++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(2 * c)) begin
        tests_failed++;
        $display("FAIL stream_req c%0d: got req=%b addr=%h want req=1 addr=%h", c, imem_req_o, imem_addr_o, 32'(2 * c));
      end
      tests_run++;
      if (is_valid_o !== (c >= 2)) begin
        tests_failed++; $display("FAIL stream_valid c%0d: got %b want %b", c, is_valid_o, (c >= 2));
      end
      if (c >= 2) begin
        tests_run++;
        if (program_counter_o !== 32'(2 * (c - 2)) || instruction_o !== mem_data(32'(2 * (c - 2)))) begin
          tests_failed++;
          $display("FAIL stream_out c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, program_counter_o,
                   instruction_o, 32'(2 * (c - 2)), mem_data(32'(2 * (c - 2))));
        end
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_stall();
    bit          er [13];
    logic [31:0] ea [13];
    bit          ev [13];
    logic [31:0] ep [13];
    er = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    ea = '{0, 2, 4, 6, 8, 10, 12, 12, 12, 12, 14, 16, 18};
    ev = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    ep = '{0, 0, 0, 2, 4, 6, 6, 6, 6, 8, 10, 12, 14};
    do_reset(1);
    for (int c = 0; c < 13; c++) begin
      stall_i = (c >= 5 && c <= 7);
      @(negedge clk_i);
      tests_run++;
      if (imem_req_o !== er[c] || imem_addr_o !== ea[c]) begin
        tests_failed++;
        $display("FAIL stall_req c%0d: got req=%b addr=%h want req=%b addr=%h", c, imem_req_o, imem_addr_o, er[c], ea[c]);
      end
      tests_run++;
      if (is_valid_o !== ev[c]) begin
        tests_failed++; $display("FAIL stall_valid c%0d: got %b want %b", c, is_valid_o, ev[c]);
      end
      if (ev[c]) begin
        tests_run++;
        if (program_counter_o !== ep[c] || instruction_o !== mem_data(ep[c])) begin
          tests_failed++;
          $display("FAIL stall_out c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, program_counter_o,
                   instruction_o, ep[c], mem_data(ep[c]));
        end
      end
      @(posedge clk_i); #1;
    end
    stall_i = 1'b0;
  endtask

  task automatic test_flush_drop();
    bit          er [10];
    logic [31:0] ea [10];
    bit          ev [10];
    logic [31:0] ep [10];
    er = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    ea = '{32'h0, 32'h2, 32'h4, 32'h100, 32'h100, 32'h102, 32'h104, 32'h104, 32'h104, 32'h106};
    ev = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    ep = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h102};
    do_reset(3);
    branch_target_i = 32'h100;
    for (int c = 0; c < 10; c++) begin
      flush_i = (c == 2);
      @(negedge clk_i);
      tests_run++;
      if (imem_req_o !== er[c] || imem_addr_o !== ea[c]) begin
        tests_failed++;
        $display("FAIL flush_drop_req c%0d: got req=%b addr=%h want req=%b addr=%h", c, imem_req_o, imem_addr_o, er[c], ea[c]);
      end
      tests_run++;
      if (is_valid_o !== ev[c]) begin
        tests_failed++; $display("FAIL flush_drop_valid c%0d: got %b want %b", c, is_valid_o, ev[c]);
      end
      if (ev[c]) begin
        tests_run++;
        if (program_counter_o !== ep[c] || instruction_o !== mem_data(ep[c])) begin
          tests_failed++;
          $display("FAIL flush_drop_out c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, program_counter_o,
                   instruction_o, ep[c], mem_data(ep[c]));
        end
      end
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0;
  endtask

  task automatic test_flush_stall();
    bit          er [9];
    logic [31:0] ea [9];
    bit          ev [9];
    logic [31:0] ep [9];
    er = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    ea = '{32'h0, 32'h2, 32'h4, 32'h6, 32'h8, 32'h200, 32'h202, 32'h204, 32'h206};
    ev = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
    ep = '{0, 0, 32'h0, 32'h2, 32'h4, 0, 0, 32'h200, 32'h202};
    do_reset(1);
    branch_target_i = 32'h200;
    for (int c = 0; c < 9; c++) begin
      flush_i = (c == 4);
      stall_i = (c == 4);
      @(negedge clk_i);
      tests_run++;
      if (imem_req_o !== er[c] || imem_addr_o !== ea[c]) begin
        tests_failed++;
        $display("FAIL flush_stall_req c%0d: got req=%b addr=%h want req=%b addr=%h", c, imem_req_o, imem_addr_o, er[c], ea[c]);
      end
      tests_run++;
      if (is_valid_o !== ev[c]) begin
        tests_failed++; $display("FAIL flush_stall_valid c%0d: got %b want %b", c, is_valid_o, ev[c]);
      end
      if (ev[c]) begin
        tests_run++;
        if (program_counter_o !== ep[c] || instruction_o !== mem_data(ep[c])) begin
          tests_failed++;
          $display("FAIL flush_stall_out c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, program_counter_o,
                   instruction_o, ep[c], mem_data(ep[c]));
        end
      end
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic test_back_to_back_flush();
    bit          er [9];
    logic [31:0] ea [9];
    bit          ev [9];
    logic [31:0] ep [9];
    er = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    ea = '{32'h0, 32'h2, 32'h4, 32'h6, 32'h300, 32'h400, 32'h402, 32'h404, 32'h406};
    ev = '{0, 0, 1, 1, 0, 0, 0, 1, 1};
    ep = '{0, 0, 32'h0, 32'h2, 0, 0, 0, 32'h400, 32'h402};
    do_reset(1);
    for (int c = 0; c < 9; c++) begin
      flush_i = (c == 3 || c == 4);
      branch_target_i = (c == 3) ? 32'h300 : 32'h400;
      @(negedge clk_i);
      tests_run++;
      if (imem_req_o !== er[c] || imem_addr_o !== ea[c]) begin
        tests_failed++;
        $display("FAIL b2b_flush_req c%0d: got req=%b addr=%h want req=%b addr=%h", c, imem_req_o, imem_addr_o, er[c], ea[c]);
      end
      tests_run++;
      if (is_valid_o !== ev[c]) begin
        tests_failed++; $display("FAIL b2b_flush_valid c%0d: got %b want %b", c, is_valid_o, ev[c]);
      end
      if (ev[c]) begin
        tests_run++;
        if (program_counter_o !== ep[c] || instruction_o !== mem_data(ep[c])) begin
          tests_failed++;
          $display("FAIL b2b_flush_out c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, program_counter_o,
                   instruction_o, ep[c], mem_data(ep[c]));
        end
      end
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0;
  endtask

  task automatic test_ready_toggle();
    logic [31:0] want_addr;
    logic [31:0] want_pc;
    do_reset(1);
    for (int c = 0; c < 12; c++) begin
      imem_ready_i = (c % 2 == 0);
      want_addr = 32'(c + (c % 2));
      want_pc = 32'(c - 2);
      @(negedge clk_i);
      tests_run++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== want_addr) begin
        tests_failed++;
        $display("FAIL ready_toggle_req c%0d: got req=%b addr=%h want req=1 addr=%h", c, imem_req_o, imem_addr_o, want_addr);
      end
      tests_run++;
      if (is_valid_o !== (c >= 2 && c % 2 == 0)) begin
        tests_failed++; $display("FAIL ready_toggle_valid c%0d: got %b want %b", c, is_valid_o, (c >= 2 && c % 2 == 0));
      end
      if (c >= 2 && c % 2 == 0) begin
        tests_run++;
        if (program_counter_o !== want_pc || instruction_o !== mem_data(want_pc)) begin
          tests_failed++;
          $display("FAIL ready_toggle_out c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, program_counter_o,
                   instruction_o, want_pc, mem_data(want_pc));
        end
      end
      @(posedge clk_i); #1;
    end
    imem_ready_i = 1'b1;
  endtask

  task automatic test_wrap();
    bit          er [7];
    logic [31:0] ea [7];
    bit          ev [7];
    logic [31:0] ep [7];
    er = '{1, 1, 0, 1, 1, 1, 1};
    ea = '{32'h0, 32'h2, 32'h4, 32'hFFFF_FFFE, 32'h0, 32'h2, 32'h4};
    ev = '{0, 0, 1, 0, 0, 1, 1};
    ep = '{0, 0, 32'h0, 0, 0, 32'hFFFF_FFFE, 32'h0};
    do_reset(1);
    branch_target_i = 32'hFFFF_FFFE;
    for (int c = 0; c < 7; c++) begin
      flush_i = (c == 2);
      @(negedge clk_i);
      tests_run++;
      if (imem_req_o !== er[c] || imem_addr_o !== ea[c]) begin
        tests_failed++;
        $display("FAIL wrap_req c%0d: got req=%b addr=%h want req=%b addr=%h", c, imem_req_o, imem_addr_o, er[c], ea[c]);
      end
      tests_run++;
      if (is_valid_o !== ev[c]) begin
        tests_failed++; $display("FAIL wrap_valid c%0d: got %b want %b", c, is_valid_o, ev[c]);
      end
      if (ev[c]) begin
        tests_run++;
        if (program_counter_o !== ep[c] || instruction_o !== mem_data(ep[c])) begin
          tests_failed++;
          $display("FAIL wrap_out c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, program_counter_o,
                   instruction_o, ep[c], mem_data(ep[c]));
        end
      end
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    repeat (5) begin
      @(posedge clk_i); #1;
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (imem_req_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_req: got %b want 0", imem_req_o);
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      tests_failed++; $display("FAIL reset_mid_restart: got req=%b addr=%h want req=1 addr=00000000", imem_req_o, imem_addr_o);
    end
    tests_run++;
    if (is_valid_o !== 1'b0 || program_counter_o !== 32'h0 || instruction_o !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_out: got valid=%b pc=%h instr=%h want valid=0 pc=00000000 instr=0000",
               is_valid_o, program_counter_o, instruction_o);
    end
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    tests_run++;
    if (is_valid_o !== 1'b1 || program_counter_o !== 32'h0 || instruction_o !== mem_data(32'h0)) begin
      tests_failed++;
      $display("FAIL reset_mid_first: got valid=%b pc=%h instr=%h want valid=1 pc=00000000 instr=%h",
               is_valid_o, program_counter_o, instruction_o, mem_data(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_drop();
    test_flush_stall();
    test_back_to_back_flush();
    test_ready_toggle();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
